// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Types shared by the traffic-light command path:
//   cmd_type_e       - command encoding understood by the light controller
//   deframer_state_e - byte position inside a command frame
//   err_code_e       - reason a frame was rejected by the deframer
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [2:0] {
        TURN_ON         = 3'd0,
        TURN_OFF        = 3'd1,
        SET_UNC         = 3'd2,
        SET_GREEN_TIME  = 3'd3,
        SET_RED_TIME    = 3'd4,
        SET_YELLOW_TIME = 3'd5
    } cmd_type_e;

    typedef enum logic [2:0] {
        SYNC_S = 3'd0,
        TYPE_S = 3'd1,
        DHI_S  = 3'd2,
        DLO_S  = 3'd3,
        CSUM_S = 3'd4
    } deframer_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_TYPE    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

endpackage

// File: rtl/gap_timer.sv
// -----------------------------------------------------------------------------
// gap_timer
// Counts idle clocks between bytes of a frame and flags a stalled frame.
// Ports:
//   clk_i    - clock
//   srst_n_i - synchronous active-low reset
//   run      - count enable (high while a frame is in progress)
//   clear    - a byte was accepted this cycle; restart the gap count
//   expired  - single-cycle flag: the gap limit is hit in this cycle and no
//              byte arrived to rescue the frame
// -----------------------------------------------------------------------------
module gap_timer #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000
) (
    input  logic clk_i,
    input  logic srst_n_i,
    input  logic run,
    input  logic clear,
    output logic expired
);

    logic [19:0] cnt;

    // A byte in the expiry cycle wins, so clear masks the expiry.
    assign expired = run && !clear && (cnt == (TIMEOUT_CYCLES - 20'd1));

    always_ff @(posedge clk_i) begin
        if (!srst_n_i || !run || clear || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 20'd1;
        end
    end

endmodule

// File: rtl/traffic_cmd_deframer.sv
// -----------------------------------------------------------------------------
// traffic_cmd_deframer
// Assembles 5-byte command frames (SYNC, TYPE, DATA_HI, DATA_LO, CSUM) from a
// byte stream and hands good commands to the traffic-light controller.
// Ports:
//   clk_i        - clock
//   srst_n_i     - synchronous active-low reset
//   byte_data_i  - received byte
//   byte_valid_i - byte strobe, one byte per cycle, no backpressure
//   cmd_type_o   - command type of the last good frame (held)
//   cmd_data_o   - payload of the last good frame (held)
//   cmd_valid_o  - one-cycle pulse per good frame
//   err_o        - one-cycle pulse per rejected frame
//   err_code_o   - cause of the last rejection: 1 csum, 2 type, 3 timeout
//   err_cnt_o    - rejected frame count, saturating at 255
// -----------------------------------------------------------------------------
module traffic_cmd_deframer
    import traffic_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000,
    parameter logic [2:0]  MAX_CMD_TYPE   = 3'd5
) (
    input  logic        clk_i,
    input  logic        srst_n_i,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_valid_i,
    output logic [2:0]  cmd_type_o,
    output logic [15:0] cmd_data_o,
    output logic        cmd_valid_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic [7:0]  err_cnt_o
);

    deframer_state_e state;
    logic [7:0]      type_sh;
    logic [7:0]      dhi_sh;
    logic [7:0]      dlo_sh;
    logic [7:0]      csum;
    logic            gap_expired;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic type_ok(input logic [7:0] t);
        return (t[7:3] == 5'd0) && (t[2:0] <= MAX_CMD_TYPE);
    endfunction

    gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk_i   (clk_i),
        .srst_n_i(srst_n_i),
        .run     (state != SYNC_S),
        .clear   (byte_valid_i),
        .expired (gap_expired)
    );

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state       <= SYNC_S;
            type_sh     <= '0;
            dhi_sh      <= '0;
            dlo_sh      <= '0;
            csum        <= '0;
            cmd_type_o  <= '0;
            cmd_data_o  <= '0;
            cmd_valid_o <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= ERR_NONE;
            err_cnt_o   <= '0;
        end else begin
            cmd_valid_o <= 1'b0;
            err_o       <= 1'b0;

            // Expiry can only fire in a cycle without a byte, so it never
            // competes with the byte-driven transitions below.
            if (gap_expired) begin
                state      <= SYNC_S;
                err_o      <= 1'b1;
                err_code_o <= ERR_TIMEOUT;
                err_cnt_o  <= sat_inc(err_cnt_o);
            end else if (byte_valid_i) begin
                unique case (state)
                    SYNC_S: begin
                        if (byte_data_i == SYNC_BYTE) begin
                            state <= TYPE_S;
                            csum  <= '0;
                        end
                    end
                    TYPE_S: begin
                        type_sh <= byte_data_i;
                        csum    <= csum ^ byte_data_i;
                        state   <= DHI_S;
                    end
                    DHI_S: begin
                        dhi_sh <= byte_data_i;
                        csum   <= csum ^ byte_data_i;
                        state  <= DLO_S;
                    end
                    DLO_S: begin
                        dlo_sh <= byte_data_i;
                        csum   <= csum ^ byte_data_i;
                        state  <= CSUM_S;
                    end
                    CSUM_S: begin
                        state <= SYNC_S;
                        // Checksum takes priority over the type check.
                        if (byte_data_i != csum) begin
                            err_o      <= 1'b1;
                            err_code_o <= ERR_CSUM;
                            err_cnt_o  <= sat_inc(err_cnt_o);
                        end else if (!type_ok(type_sh)) begin
                            err_o      <= 1'b1;
                            err_code_o <= ERR_TYPE;
                            err_cnt_o  <= sat_inc(err_cnt_o);
                        end else begin
                            cmd_type_o  <= type_sh[2:0];
                            cmd_data_o  <= {dhi_sh, dlo_sh};
                            cmd_valid_o <= 1'b1;
                        end
                    end
                    default: state <= SYNC_S;
                endcase
            end
        end
    end

endmodule
